// File: rtl/lht_pipe.sv
// ---------------------------------------------------------------------------
// lht_pipe : parametrised local-history table for the branch predictor front
// end.
//
// Each entry holds a HIST_W-bit shift register of resolved branch outcomes.
// The newest outcome enters at the LSB, and the oldest outcome falls off the
// MSB. Updates go through a two-stage read-modify-write pipeline:
//   U1 : fetch the old history (forwarded from U2 when U2 targets the same
//        entry), then shift the new outcome in.
//   U2 : write the new history back into the table.
// Reads are answered one cycle after they are sampled. The answer is forwarded
// from U1 or U2 when an update to the same entry is still in flight. A read
// therefore sees every update sampled at or before the read's own sample edge.
//
// After reset the block sweeps the table, clearing one entry per cycle. Read
// and update requests are ignored until that sweep is complete.
//
// Ports
//   clk        in   1       clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   init_done  out  1       1 once the clear sweep has finished
//   rd_en      in   1       read request
//   rd_idx     in   IDX_W   read index
//   rd_valid   out  1       rd_hist is valid this cycle
//   rd_hist    out  HIST_W  history for the read sampled in the previous cycle
//   upd_en     in   1       update request
//   upd_idx    in   IDX_W   update index
//   upd_taken  in   1       resolved outcome (1 = taken)
// ---------------------------------------------------------------------------
module lht_pipe #(
  parameter int DEPTH  = 256,
  parameter int HIST_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       init_done,
  input  logic                       rd_en,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic                       rd_valid,
  output logic [HIST_W-1:0]          rd_hist,
  input  logic                       upd_en,
  input  logic [$clog2(DEPTH)-1:0]   upd_idx,
  input  logic                       upd_taken
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // The history storage. It has no reset because the INIT sweep clears it.
  logic [HIST_W-1:0] mem [DEPTH];

  // Controller state
  state_t            state_q, state_d;
  logic [IDX_W-1:0]  clr_q, clr_d;

  // Update pipeline stage U1 (sampled request)
  logic              u1_valid_q, u1_valid_d;
  logic [IDX_W-1:0]  u1_idx_q, u1_idx_d;
  logic              u1_taken_q, u1_taken_d;

  // Update pipeline stage U2 (computed history awaiting write-back)
  logic              u2_valid_q, u2_valid_d;
  logic [IDX_W-1:0]  u2_idx_q, u2_idx_d;
  logic [HIST_W-1:0] u2_new_q, u2_new_d;

  // Read pipeline (one stage)
  logic              rd_valid_q, rd_valid_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;

  // Combinational U1 results
  logic [HIST_W-1:0] u1_old;
  logic [HIST_W-1:0] u1_new;

  logic              ready;

  assign ready     = (state_q == ST_READY);
  assign init_done = ready;

  // U1 reads the history it is about to modify. U2 has not written its result
  // back yet. When U2 targets the same entry, the U2 value is the
  // architecturally current one, so back-to-back updates compose correctly.
  always_comb begin
    u1_old = mem[u1_idx_q];
    if (u2_valid_q && (u2_idx_q == u1_idx_q)) begin
      u1_old = u2_new_q;
    end
    u1_new = {u1_old[HIST_W-2:0], u1_taken_q};
  end

  // Next-state logic for the clear-sweep controller and both pipelines.
  // Requests are only accepted in READY. Until then the pipelines stay empty,
  // so the sweep cannot race an update write-back.
  always_comb begin
    state_d    = state_q;
    clr_d      = clr_q;
    u1_valid_d = 1'b0;
    u1_idx_d   = u1_idx_q;
    u1_taken_d = u1_taken_q;
    u2_valid_d = 1'b0;
    u2_idx_d   = u2_idx_q;
    u2_new_d   = u2_new_q;
    rd_valid_d = 1'b0;
    rd_idx_d   = rd_idx_q;

    case (state_q)
      ST_INIT: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == LAST_IDX) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (upd_en) begin
          u1_valid_d = 1'b1;
          u1_idx_d   = upd_idx;
          u1_taken_d = upd_taken;
        end
        if (u1_valid_q) begin
          u2_valid_d = 1'b1;
          u2_idx_d   = u1_idx_q;
          u2_new_d   = u1_new;
        end
        if (rd_en) begin
          rd_valid_d = 1'b1;
          rd_idx_d   = rd_idx;
        end
      end
      default: begin
        state_d = ST_INIT;
        clr_d   = '0;
      end
    endcase
  end

  // State registers. An asynchronous reset drops every in-flight read and
  // update, and restarts the clear sweep from entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      clr_q      <= '0;
      u1_valid_q <= 1'b0;
      u1_idx_q   <= '0;
      u1_taken_q <= 1'b0;
      u2_valid_q <= 1'b0;
      u2_idx_q   <= '0;
      u2_new_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      clr_q      <= clr_d;
      u1_valid_q <= u1_valid_d;
      u1_idx_q   <= u1_idx_d;
      u1_taken_q <= u1_taken_d;
      u2_valid_q <= u2_valid_d;
      u2_idx_q   <= u2_idx_d;
      u2_new_q   <= u2_new_d;
      rd_valid_q <= rd_valid_d;
      rd_idx_q   <= rd_idx_d;
    end
  end

  // Single table write port. It is shared by the clear sweep and U2
  // write-back; the two never overlap because U2 is empty during INIT.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem[clr_q] <= '0;
    end else if (u2_valid_q) begin
      mem[u2_idx_q] <= u2_new_q;
    end
  end

  // Read response. U1 holds the youngest in-flight update, so it wins over U2,
  // and U2 wins over the table contents. With no read in flight the output is
  // held at 0.
  always_comb begin
    rd_hist = '0;
    if (rd_valid_q) begin
      if (u1_valid_q && (u1_idx_q == rd_idx_q)) begin
        rd_hist = u1_new;
      end else if (u2_valid_q && (u2_idx_q == rd_idx_q)) begin
        rd_hist = u2_new_q;
      end else begin
        rd_hist = mem[rd_idx_q];
      end
    end
  end

  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_lht_pipe.sv
// ---------------------------------------------------------------------------
// tb_lht_pipe : scoreboard bench for lht_pipe.
//
// The reference model is a plain array of histories. When a cycle's
// stimulus is issued, the model first applies that cycle's update and then
// answers that cycle's read. The answer is pushed into a queue. A monitor,
// independent of the driver, pops one expected value whenever rd_valid is
// seen.
// ---------------------------------------------------------------------------
module tb_lht_pipe;

   localparam int DEPTH  = 256;
   localparam int HIST_W = 8;
   localparam int IDX_W  = $clog2(DEPTH);

   logic              clk;
   logic              rst_n;
   logic              init_done;
   logic              rd_en;
   logic [IDX_W-1:0]  rd_idx;
   logic              rd_valid;
   logic [HIST_W-1:0] rd_hist;
   logic              upd_en;
   logic [IDX_W-1:0]  upd_idx;
   logic              upd_taken;

   int checks = 0;
   int errors = 0;

   logic [HIST_W-1:0] modelMem [DEPTH];
   logic [HIST_W-1:0] expQ [$];

   lht_pipe #(.DEPTH(DEPTH), .HIST_W(HIST_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .init_done (init_done),
      .rd_en     (rd_en),
      .rd_idx    (rd_idx),
      .rd_valid  (rd_valid),
      .rd_hist   (rd_hist),
      .upd_en    (upd_en),
      .upd_idx   (upd_idx),
      .upd_taken (upd_taken)
   );

   // 10 time-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Record one comparison and report it if it disagrees
   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   // Drive one cycle of traffic, starting from just after a rising edge.
   // The model takes the update before the read, because a same-cycle update
   // to the same entry must be visible to the read.
   task automatic applyStimulus(input logic re, input int ri,
                                input logic ue, input int ui, input logic t);
      logic [IDX_W-1:0] r;
      logic [IDX_W-1:0] u;
      r = ri[IDX_W-1:0];
      u = ui[IDX_W-1:0];
      rd_en     = re;
      rd_idx    = r;
      upd_en    = ue;
      upd_idx   = u;
      upd_taken = t;
      if (ue) modelMem[u] = {modelMem[u][HIST_W-2:0], t};
      if (re) expQ.push_back(modelMem[u == r && ue ? u : r]);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
   endtask

   // Release reset and count edges until init_done rises. Random requests
   // are issued throughout INIT and must all be ignored.
   task automatic waitInit();
      int n;
      n = 0;
      for (int i = 0; i < DEPTH; i++) modelMem[i] = '0;
      rd_en = 1'b0;
      upd_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      while (1) begin
         @(posedge clk);
         #1;
         n++;
         if (init_done) break;
         if (n > 2 * DEPTH) break;
         rd_en     = 1'($urandom_range(0, 1));
         rd_idx    = IDX_W'($urandom);
         upd_en    = 1'($urandom_range(0, 1));
         upd_idx   = IDX_W'($urandom);
         upd_taken = 1'($urandom_range(0, 1));
      end
      rd_en  = 1'b0;
      upd_en = 1'b0;
      checkOutput("init latency", n, DEPTH);
   endtask

   // Monitor: sample mid-cycle, away from the rising edge
   always @(negedge clk) begin
      if (rd_valid) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected rd_valid", 1, 0);
         end else begin
            checkOutput("rd_hist", int'(rd_hist), int'(expQ.pop_front()));
         end
      end else begin
         checkOutput("idle rd_hist", int'(rd_hist), 0);
      end
   end

   logic [3:0] patA;
   logic [3:0] patB;

   initial begin
      rst_n     = 1'b0;
      rd_en     = 1'b0;
      rd_idx    = '0;
      upd_en    = 1'b0;
      upd_idx   = '0;
      upd_taken = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset init_done", int'(init_done), 0);
      checkOutput("reset rd_valid", int'(rd_valid), 0);

      waitInit();

      // Every entry reads back as cleared
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, i, 1'b0, 0, 1'b0);
      idle(2);

      // Single update, read three cycles later
      applyStimulus(1'b0, 0, 1'b1, 'h12, 1'b1);
      idle(2);
      applyStimulus(1'b1, 'h12, 1'b0, 0, 1'b0);

      // Back-to-back updates to one entry: 1,1,0,1
      applyStimulus(1'b0, 0, 1'b1, 'h05, 1'b1);
      applyStimulus(1'b0, 0, 1'b1, 'h05, 1'b1);
      applyStimulus(1'b0, 0, 1'b1, 'h05, 1'b0);
      applyStimulus(1'b0, 0, 1'b1, 'h05, 1'b1);
      applyStimulus(1'b1, 'h05, 1'b0, 0, 1'b0);

      // Ten taken updates overflow the history; the MSB is dropped
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 0, 1'b1, 'h06, 1'b1);
      applyStimulus(1'b1, 'h06, 1'b0, 0, 1'b0);
      idle(3);
      applyStimulus(1'b1, 'h06, 1'b0, 0, 1'b0);

      // Same-cycle update and read, then reads one and two cycles after
      applyStimulus(1'b1, 'h20, 1'b1, 'h20, 1'b1);
      applyStimulus(1'b0, 0, 1'b1, 'h21, 1'b1);
      applyStimulus(1'b1, 'h21, 1'b0, 0, 1'b0);
      applyStimulus(1'b0, 0, 1'b1, 'h22, 1'b1);
      applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
      applyStimulus(1'b1, 'h22, 1'b0, 0, 1'b0);

      // Interleaved neighbours, each read aimed at the other index
      patA = 4'b1010;
      patB = 4'b0110;
      for (int i = 3; i >= 0; i--) begin
         applyStimulus(1'b1, 'h31, 1'b1, 'h30, patA[i]);
         applyStimulus(1'b1, 'h30, 1'b1, 'h31, patB[i]);
      end
      applyStimulus(1'b1, 'h30, 1'b0, 0, 1'b0);
      applyStimulus(1'b1, 'h31, 1'b0, 0, 1'b0);

      // Random traffic, first over a tiny index set to force collisions
      for (int i = 0; i < 1500; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 1500; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                       1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                       1'($urandom_range(0, 1)));
      end
      idle(3);
      checkOutput("scoreboard drained", expQ.size(), 0);

      // Reset with U1, U2 and a read all in flight
      applyStimulus(1'b0, 0, 1'b1, 'h40, 1'b1);
      applyStimulus(1'b1, 'h40, 1'b1, 'h41, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset rd_valid", int'(rd_valid), 0);
      checkOutput("midreset rd_hist", int'(rd_hist), 0);
      checkOutput("midreset init_done", int'(init_done), 0);
      expQ.delete();
      rd_en  = 1'b0;
      upd_en = 1'b0;
      repeat (2) @(posedge clk);

      waitInit();
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, i, 1'b0, 0, 1'b0);
      idle(3);
      checkOutput("final drained", expQ.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Overall time limit
   initial begin
      #2000000;
      $display("[TB] FAIL timeout actual=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
